// File: rtl/cpu_pkg.sv
// Shared definitions for the Harvard MIPS core: PC sequencer state encoding and
// default fetch/halt addresses.
package cpu_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DSLOT = 2'd1,
    HALT  = 2'd2
  } pcseq_state_t;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC00000;
  localparam logic [31:0] HALT_ADDR_DEFAULT    = 32'h00000000;
  localparam logic [31:0] INSTR_BYTES          = 32'd4;

endpackage

// File: rtl/pc_sequencer.sv
// Program-counter controller: sequential fetch, one-delay-slot redirects, stall/enable
// freeze and halt detection. Optional misaligned-redirect trap under PC_ALIGN_CHECK_EN.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter logic [31:0] HALT_ADDR    = HALT_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] instr_address,
  output logic [31:0] link_address,
  output logic        delay_slot,
  output logic        active,
  output logic        fault
);

  pcseq_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pending_q, pending_d;
  logic         active_q, active_d;
  logic         advance;
  logic [31:0]  pc_plus4;
  logic [31:0]  target_latch;

`ifdef PC_ALIGN_CHECK_EN
  logic fault_q, fault_d;
  assign target_latch = redirect_target;
`else
  // Without the trap, misaligned targets are silently word-aligned.
  assign target_latch = redirect_target & 32'hFFFF_FFFC;
`endif

  assign advance  = clk_enable & ~stall;
  assign pc_plus4 = pc_q + INSTR_BYTES;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pending_d = pending_q;
    active_d  = active_q;
`ifdef PC_ALIGN_CHECK_EN
    fault_d   = fault_q;
`endif
    if (advance) begin
      case (state_q)
        RUN: begin
          pc_d = pc_plus4;
          if (redirect_valid) begin
            pending_d = target_latch;
            state_d   = DSLOT;
`ifdef PC_ALIGN_CHECK_EN
            fault_d   = fault_q | (redirect_target[1:0] != 2'b00);
`endif
          end
          if (pc_plus4 == HALT_ADDR) begin
            state_d  = HALT;
            active_d = 1'b0;
          end
        end
        DSLOT: begin
`ifdef PC_ALIGN_CHECK_EN
          // fault can only be set here by the redirect that opened this slot,
          // since any earlier fault would already have halted the core.
          pc_d = fault_q ? HALT_ADDR : pending_q;
`else
          pc_d = pending_q;
`endif
          if (pc_d == HALT_ADDR) begin
            state_d  = HALT;
            active_d = 1'b0;
          end else begin
            state_d  = RUN;
          end
        end
        default: begin
          state_d = HALT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= RUN;
      pc_q      <= RESET_VECTOR;
      pending_q <= 32'd0;
      active_q  <= 1'b1;
`ifdef PC_ALIGN_CHECK_EN
      fault_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pending_q <= pending_d;
      active_q  <= active_d;
`ifdef PC_ALIGN_CHECK_EN
      fault_q   <= fault_d;
`endif
    end
  end

  assign instr_address = pc_q;
  assign link_address  = pc_q + 32'd8;
  assign delay_slot    = (state_q == DSLOT);
  assign active        = active_q;
`ifdef PC_ALIGN_CHECK_EN
  assign fault         = fault_q;
`else
  assign fault         = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, hand sequences for
// reset/alignment/wrap corners, and randomized traffic against a behavioural model.
module tb_pc_sequencer;

  localparam logic [31:0] RV    = 32'hBFC00000;
  localparam logic [31:0] HADDR = 32'h00000000;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_enable;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] instr_address;
  logic [31:0] link_address;
  logic        delay_slot;
  logic        active;
  logic        fault;

  int checks = 0;
  int errors = 0;

  pc_sequencer #(.RESET_VECTOR(RV), .HALT_ADDR(HADDR)) dut (
    .clk            (clk),
    .reset          (reset),
    .clk_enable     (clk_enable),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .instr_address  (instr_address),
    .link_address   (link_address),
    .delay_slot     (delay_slot),
    .active         (active),
    .fault          (fault)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural model: architectural PC plus "a target is owed after one slot".
  logic [31:0] m_pc;
  logic [31:0] m_owed;
  bit          m_in_slot;
  bit          m_halted;
  bit          m_fault;
  bit          m_bad_owed;
`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  task automatic model_reset();
    m_pc = RV; m_owed = 32'd0; m_in_slot = 0; m_halted = 0; m_fault = 0; m_bad_owed = 0;
  endtask

  task automatic model_step(input bit ce, input bit st, input bit rv, input logic [31:0] tgt);
    if (!ce || st || m_halted) return;
    if (m_in_slot) begin
      m_in_slot = 0;
      m_pc = m_bad_owed ? HADDR : m_owed;
    end else begin
      if (rv) begin
        m_in_slot = 1;
        if (ALIGN_EN) begin
          m_owed = tgt;
          if (tgt[1:0] != 2'b00) begin
            m_fault = 1; m_bad_owed = 1;
          end
        end else begin
          m_owed = {tgt[31:2], 2'b00};
        end
      end
      m_pc = m_pc + 32'd4;
    end
    if (m_pc == HADDR) begin
      m_halted = 1; m_in_slot = 0;
    end
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, " pc"},     instr_address,        m_pc);
    check({tag, " link"},   link_address,         m_pc + 32'd8);
    check({tag, " dslot"},  {31'd0, delay_slot},  {31'd0, m_in_slot});
    check({tag, " active"}, {31'd0, active},      {31'd0, !m_halted});
    check({tag, " fault"},  {31'd0, fault},       {31'd0, m_fault});
  endtask

  // Apply inputs for one cycle; outputs are sampled 1 time unit after the edge.
  task automatic drive(input bit ce, input bit st, input bit rv, input logic [31:0] tgt);
    clk_enable = ce; stall = st; redirect_valid = rv; redirect_target = tgt;
    @(posedge clk);
    #1;
    model_step(ce, st, rv, tgt);
  endtask

  // Asynchronous reset pulse between clock edges; outputs checked while reset is low.
  task automatic reset_pulse(input string tag);
    @(negedge clk);
    reset = 1'b0;
    #1;
    model_reset();
    check({tag, " rst pc"}, instr_address, RV);
    check({tag, " rst dslot"}, {31'd0, delay_slot}, 32'd0);
    check({tag, " rst active"}, {31'd0, active}, 32'd1);
    check({tag, " rst fault"}, {31'd0, fault}, 32'd0);
    #1;
    reset = 1'b1;
  endtask

  typedef struct {
    bit          ce;
    bit          st;
    bit          rv;
    logic [31:0] tgt;
    logic [31:0] pc;
    bit          ds;
    bit          act;
  } vec_t;

  vec_t vecs[15];

  initial begin
    vecs[0]  = '{1, 0, 0, 32'h0,          32'hBFC00004, 0, 1};
    vecs[1]  = '{1, 0, 0, 32'h0,          32'hBFC00008, 0, 1};
    vecs[2]  = '{1, 0, 1, 32'hBFC00018,   32'hBFC0000C, 1, 1};
    vecs[3]  = '{1, 0, 0, 32'h0,          32'hBFC00018, 0, 1};
    vecs[4]  = '{1, 0, 1, 32'hBFC00040,   32'hBFC0001C, 1, 1};
    vecs[5]  = '{1, 1, 1, 32'hBFC00040,   32'hBFC0001C, 1, 1};
    vecs[6]  = '{1, 1, 1, 32'hBFC00040,   32'hBFC0001C, 1, 1};
    vecs[7]  = '{1, 1, 1, 32'hBFC00040,   32'hBFC0001C, 1, 1};
    vecs[8]  = '{0, 0, 1, 32'hBFC00040,   32'hBFC0001C, 1, 1};
    vecs[9]  = '{0, 0, 1, 32'hBFC00040,   32'hBFC0001C, 1, 1};
    vecs[10] = '{1, 0, 0, 32'h0,          32'hBFC00040, 0, 1};
    vecs[11] = '{1, 0, 1, 32'h0,          32'hBFC00044, 1, 1};
    vecs[12] = '{1, 0, 0, 32'h0,          32'h00000000, 0, 0};
    vecs[13] = '{1, 0, 1, 32'hBFC00000,   32'h00000000, 0, 0};
    vecs[14] = '{1, 0, 0, 32'h0,          32'h00000000, 0, 0};

    reset = 1'b0; clk_enable = 1'b0; stall = 1'b0;
    redirect_valid = 1'b0; redirect_target = 32'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset pc", instr_address, RV);
    check("reset link", link_address, 32'hBFC00008);
    check("reset active", {31'd0, active}, 32'd1);
    check("reset dslot", {31'd0, delay_slot}, 32'd0);
    check("reset fault", {31'd0, fault}, 32'd0);
    #2;
    reset = 1'b1;

    // Directed table
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].ce, vecs[i].st, vecs[i].rv, vecs[i].tgt);
      $display("vec %0d: ce=%0b st=%0b rv=%0b tgt=%08h -> pc=%08h ds=%0b act=%0b",
               i, vecs[i].ce, vecs[i].st, vecs[i].rv, vecs[i].tgt,
               instr_address, delay_slot, active);
      check($sformatf("vec%0d pc", i), instr_address, vecs[i].pc);
      check($sformatf("vec%0d link", i), link_address, vecs[i].pc + 32'd8);
      check($sformatf("vec%0d dslot", i), {31'd0, delay_slot}, {31'd0, vecs[i].ds});
      check($sformatf("vec%0d active", i), {31'd0, active}, {31'd0, vecs[i].act});
    end

    // Reset in the middle of a delay slot discards the owed target
    reset_pulse("pre-dslot");
    drive(1, 0, 1, 32'hBFC00100);
    $display("dslot-reset: pc=%08h ds=%0b", instr_address, delay_slot);
    check("dslot entered", {31'd0, delay_slot}, 32'd1);
    reset_pulse("mid-dslot");
    drive(1, 0, 0, 32'h0);
    $display("after mid-dslot reset: pc=%08h ds=%0b", instr_address, delay_slot);
    check("post-reset pc", instr_address, 32'hBFC00004);
    check("post-reset dslot", {31'd0, delay_slot}, 32'd0);

    // Misaligned redirect target
    drive(1, 0, 1, 32'hBFC00022);
    $display("misaligned redirect: pc=%08h ds=%0b", instr_address, delay_slot);
    check("misalign slot pc", instr_address, 32'hBFC00008);
    check("misalign slot ds", {31'd0, delay_slot}, 32'd1);
    drive(1, 0, 0, 32'h0);
    $display("misaligned target: pc=%08h fault=%0b act=%0b", instr_address, fault, active);
`ifdef PC_ALIGN_CHECK_EN
    check("misalign pc", instr_address, 32'h00000000);
    check("misalign fault", {31'd0, fault}, 32'd1);
    check("misalign active", {31'd0, active}, 32'd0);
`else
    check("misalign pc", instr_address, 32'hBFC00020);
    check("misalign fault", {31'd0, fault}, 32'd0);
    check("misalign active", {31'd0, active}, 32'd1);
`endif

    // Sequential wrap from FFFFFFFC to 0 halts
    reset_pulse("wrap");
    drive(1, 0, 1, 32'hFFFFFFF8);
    drive(1, 0, 0, 32'h0);
    check("wrap pc F8", instr_address, 32'hFFFFFFF8);
    check("wrap link F8", link_address, 32'h00000000);
    drive(1, 0, 0, 32'h0);
    check("wrap pc FC", instr_address, 32'hFFFFFFFC);
    check("wrap link FC", link_address, 32'h00000004);
    check("wrap active FC", {31'd0, active}, 32'd1);
    drive(1, 0, 0, 32'h0);
    $display("wrap: pc=%08h act=%0b", instr_address, active);
    check("wrap pc 0", instr_address, 32'h00000000);
    check("wrap halted", {31'd0, active}, 32'd0);

    // Randomized traffic against the model
    reset_pulse("rand");
    for (int n = 0; n < 2000; n++) begin
      bit          ce, st, rv;
      logic [31:0] tgt;
      int          sel;
      if ((m_halted && ($urandom % 4 == 0)) || ($urandom % 300 == 0)) begin
        reset_pulse($sformatf("rand%0d", n));
      end
      ce  = ($urandom % 8) != 0;
      st  = ($urandom % 6) == 0;
      rv  = ($urandom % 5) == 0;
      sel = $urandom % 32;
      if (sel == 0)       tgt = 32'h0;
      else if (sel == 1)  tgt = 32'hFFFFFFF8;
      else if (sel < 4)   tgt = RV + 32'(($urandom % 256) * 4) + 32'($urandom_range(1, 3));
      else                tgt = RV + 32'(($urandom % 256) * 4);
      drive(ce, st, rv, tgt);
      check_model($sformatf("rand%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
